cpu7_exu_wbarb: RTL and testbench

- Writeback arbiter sitting directly upstream of the integer register file.
- Collects results from three producers and drives the register file's two write ports with one registered stage:
  - ALU pipe: single-cycle, no backpressure.
  - LSU: load data, valid/ready.
  - MUL/DIV unit: valid/ready.
- Arbitrates the long-latency producers fairly, suppresses r0 writes, and orders writes so the register file's port-2-wins collision rule is safe.

---
 rtl/cpu7_exu_pkg.sv | 11 +
 rtl/cpu7_exu_rr2.sv | 20 ++
 rtl/cpu7_exu_wbarb.sv | 86 ++++++++
 tb/tb_cpu7_exu_wbarb.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu7_exu_pkg.sv
// cpu7_exu_pkg: shared widths, writeback request type and r0 constant for the EXU writeback path.
package cpu7_exu_pkg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
   } wb_req_t;
endpackage

// File: rtl/cpu7_exu_rr2.sv
// cpu7_exu_rr2: two-requester round-robin arbiter; slot_cnt is how many grants may be issued this cycle.
module cpu7_exu_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] slot_cnt,
   output logic [1:0] gnt
);
   logic rr_q, rr_d;
   always_comb begin
      gnt  = (slot_cnt == 2'd0) ? 2'b00 :
             (&req && slot_cnt == 2'd1) ? (rr_q ? 2'b10 : 2'b01) : req;
      // after a contended single grant, favour the loser (gnt[0] set means requester 1 lost)
      rr_d = (&req && ^gnt) ? gnt[0] : rr_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
endmodule

// File: rtl/cpu7_exu_wbarb.sv
// cpu7_exu_wbarb: merges ALU, LSU and MUL/DIV results onto the two register-file write ports, one registered stage.
// Define CPU7_WB_PERF_EN to add 32-bit per-source stall counters.
module cpu7_exu_wbarb
   import cpu7_exu_pkg::*;
#(
   parameter int DW = cpu7_exu_pkg::DW,
   parameter int AW = cpu7_exu_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_waddr,
   input  logic [DW-1:0] alu_wdata,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_waddr,
   input  logic [DW-1:0] lsu_wdata,
   input  logic          mul_valid,
   output logic          mul_ready,
   input  logic [AW-1:0] mul_waddr,
   input  logic [DW-1:0] mul_wdata,
   output logic          wen1,
   output logic [AW-1:0] waddr1,
   output logic [DW-1:0] wdata1,
   output logic          wen2,
   output logic [AW-1:0] waddr2,
   output logic [DW-1:0] wdata2
`ifdef CPU7_WB_PERF_EN
   ,
   output logic [31:0]   perf_lsu_stall,
   output logic [31:0]   perf_mul_stall
`endif
);
   wb_req_t alu_r, lsu_r, mul_r, p1_d, p2_d, p1_q, p2_q;
   logic [1:0] gnt;
   assign alu_r = {alu_valid, alu_waddr, alu_wdata};
   assign lsu_r = {lsu_valid, lsu_waddr, lsu_wdata};
   assign mul_r = {mul_valid, mul_waddr, mul_wdata};
   cpu7_exu_rr2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      ({mul_valid, lsu_valid}),
      .slot_cnt (alu_valid ? 2'd1 : 2'd2),
      .gnt      (gnt)
   );
   assign lsu_ready = gnt[0] & ~rst;
   assign mul_ready = gnt[1] & ~rst;
   // port 1 carries MUL only when the ALU is idle and both long-latency sources won
   always_comb begin
      p1_d       = alu_valid ? alu_r : mul_r;
      p1_d.valid = alu_valid | (&gnt);
      p2_d       = gnt[0] ? lsu_r : mul_r;
      p2_d.valid = |gnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_q <= '0;
         p2_q <= '0;
      end else begin
         p1_q.valid <= p1_d.valid && p1_d.waddr != REG_ZERO;
         p2_q.valid <= p2_d.valid && p2_d.waddr != REG_ZERO;
         if (p1_d.valid) {p1_q.waddr, p1_q.wdata} <= {p1_d.waddr, p1_d.wdata};
         if (p2_d.valid) {p2_q.waddr, p2_q.wdata} <= {p2_d.waddr, p2_d.wdata};
      end
   end
   assign wen1   = p1_q.valid;
   assign waddr1 = p1_q.waddr;
   assign wdata1 = p1_q.wdata;
   assign wen2   = p2_q.valid;
   assign waddr2 = p2_q.waddr;
   assign wdata2 = p2_q.wdata;
`ifdef CPU7_WB_PERF_EN
   logic [31:0] perf_lsu_q, perf_mul_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_lsu_q <= '0;
         perf_mul_q <= '0;
      end else begin
         perf_lsu_q <= perf_lsu_q + 32'(lsu_valid & ~lsu_ready);
         perf_mul_q <= perf_mul_q + 32'(mul_valid & ~mul_ready);
      end
   end
   assign perf_lsu_stall = perf_lsu_q;
   assign perf_mul_stall = perf_mul_q;
`endif
endmodule

// File: tb/tb_cpu7_exu_wbarb.sv
// tb_cpu7_exu_wbarb: scoreboard bench for the writeback arbiter; expected writes queued at drive time, popped one cycle later.
module tb_cpu7_exu_wbarb;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0, lsu_valid = 1'b0, mul_valid = 1'b0;
   logic [4:0]  alu_waddr = '0, lsu_waddr = '0, mul_waddr = '0;
   logic [31:0] alu_wdata = '0, lsu_wdata = '0, mul_wdata = '0;
   logic        lsu_ready, mul_ready, wen1, wen2;
   logic [4:0]  waddr1, waddr2;
   logic [31:0] wdata1, wdata2;
`ifdef CPU7_WB_PERF_EN
   logic [31:0] perf_lsu_stall, perf_mul_stall;
`endif
   typedef struct packed {
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        w2;
      logic [4:0]  a2;
      logic [31:0] d2;
   } exp_t;
   exp_t        sb[$];
   int          checks = 0, errors = 0;
   logic        rr_m = 1'b0;
   logic [4:0]  la1 = '0, la2 = '0;
   logic [31:0] ld1 = '0, ld2 = '0;

   always #5 clk = ~clk;

   cpu7_exu_wbarb dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_waddr(mul_waddr), .mul_wdata(mul_wdata),
      .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
      .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2)
`ifdef CPU7_WB_PERF_EN
      , .perf_lsu_stall(perf_lsu_stall), .perf_mul_stall(perf_mul_stall)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic predict(output logic lg, output logic mg);
      lg = lsu_valid && !(alu_valid && mul_valid && rr_m);
      mg = mul_valid && !(alu_valid && lsu_valid && !rr_m);
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ldat,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      alu_valid = av; alu_waddr = aa; alu_wdata = ad;
      lsu_valid = lv; lsu_waddr = la; lsu_wdata = ldat;
      mul_valid = mv; mul_waddr = ma; mul_wdata = md;
   endtask

   // starts and ends 1 time unit after a rising edge
   task automatic cyc(input logic er_l, input logic er_m);
      exp_t e;
      logic lg, mg, p1v, p2v;
      logic [4:0] p1a, p2a;
      logic [31:0] p1d, p2d;
      #3;
      chk("lsu_ready", 64'(lsu_ready), 64'(er_l));
      chk("mul_ready", 64'(mul_ready), 64'(er_m));
      predict(lg, mg);
      if (alu_valid && lsu_valid && mul_valid) rr_m = !rr_m;
      p1v = alu_valid || (lg && mg);
      p1a = alu_valid ? alu_waddr : mul_waddr;
      p1d = alu_valid ? alu_wdata : mul_wdata;
      p2v = lg || mg;
      p2a = lg ? lsu_waddr : mul_waddr;
      p2d = lg ? lsu_wdata : mul_wdata;
      if (p1v) begin la1 = p1a; ld1 = p1d; end
      if (p2v) begin la2 = p2a; ld2 = p2d; end
      e = '{w1: p1v && p1a != 5'd0, a1: la1, d1: ld1, w2: p2v && p2a != 5'd0, a2: la2, d2: ld2};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("wen1", 64'(wen1), 64'(e.w1));
      chk("waddr1", 64'(waddr1), 64'(e.a1));
      chk("wdata1", 64'(wdata1), 64'(e.d1));
      chk("wen2", 64'(wen2), 64'(e.w2));
      chk("waddr2", 64'(waddr2), 64'(e.a2));
      chk("wdata2", 64'(wdata2), 64'(e.d2));
   endtask

   initial begin
      logic lg, mg;
      #1;
      chk("rst_wen1", 64'(wen1), 64'd0);
      chk("rst_wen2", 64'(wen2), 64'd0);
      chk("rst_waddr1", 64'(waddr1), 64'd0);
      chk("rst_wdata2", 64'(wdata2), 64'd0);
      drive(0, 0, 0, 1, 4, 32'h44, 1, 5, 32'h55);
      #1;
      chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      chk("rst_mul_ready", 64'(mul_ready), 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 3, 32'h11, 0, 0, 0, 0, 0, 0);
      cyc(0, 0);
      chk("alu_wdata1", 64'(wdata1), 64'h11);
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(8 + i), 32'(i), 1, 4, 32'h440 + 32'(i), 1, 5, 32'h550 + 32'(i));
         cyc(i % 2 == 0, i % 2 == 1);
         chk("alt_waddr2", 64'(waddr2), (i % 2 == 0) ? 64'd4 : 64'd5);
      end
      drive(0, 0, 0, 1, 6, 32'hAA, 1, 7, 32'hBB);
      cyc(1, 1);
      chk("dual_waddr1", 64'(waddr1), 64'd7);
      chk("dual_wdata2", 64'(wdata2), 64'hAA);
      drive(1, 2, 32'h22, 1, 4, 32'h4, 1, 5, 32'h5);
      cyc(1, 0);
      drive(1, 0, 32'h99, 0, 0, 0, 0, 0, 0);
      cyc(0, 0);
      chk("r0_wen1", 64'(wen1), 64'd0);
      drive(0, 0, 0, 1, 0, 32'h77, 0, 0, 0);
      cyc(1, 0);
      chk("r0_wen2", 64'(wen2), 64'd0);
      drive(1, 3, 32'h33, 1, 4, 32'h4, 1, 5, 32'h5);
      cyc(0, 1);
      drive(0, 0, 0, 0, 0, 0, 1, 12, 32'hC);
      cyc(0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0);
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
               1'($urandom), 5'($urandom), $urandom);
         predict(lg, mg);
         cyc(lg, mg);
      end
      drive(1, 9, 32'h909, 0, 0, 0, 0, 0, 0);
      cyc(0, 0);
      chk("pre_rst_wen1", 64'(wen1), 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_wen1", 64'(wen1), 64'd0);
      chk("async_wen2", 64'(wen2), 64'd0);
      drive(0, 0, 0, 1, 4, 0, 1, 5, 0);
      #1;
      chk("async_lsu_ready", 64'(lsu_ready), 64'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rr_m = 1'b0; la1 = '0; la2 = '0; ld1 = '0; ld2 = '0;
      drive(1, 1, 32'h1, 1, 4, 32'hD4, 1, 5, 32'hD5);
      cyc(1, 0);
      chk("post_rst_waddr2", 64'(waddr2), 64'd4);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
